// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-interface definitions: word width, memory-mapped IO
// addresses and the access FSM state type.
package lc3_pkg;

  localparam int unsigned LC3_W = 16;

  localparam logic [LC3_W-1:0] LC3_KBSR_ADDR = 16'hFE00;
  localparam logic [LC3_W-1:0] LC3_KBDR_ADDR = 16'hFE02;
  localparam logic [LC3_W-1:0] LC3_DSR_ADDR  = 16'hFE04;
  localparam logic [LC3_W-1:0] LC3_DDR_ADDR  = 16'hFE06;

  typedef enum logic [1:0] {
    IDLE,
    MEM,
    DONE
  } mem_state_t;

endpackage

// File: rtl/lc3_io_regs.sv
// Memory-mapped keyboard/display registers: read mux plus the keyboard
// capture and display hand-off handshakes.
module lc3_io_regs
  import lc3_pkg::*;
#(
  parameter logic [LC3_W-1:0] KBSR_ADDR = LC3_KBSR_ADDR,
  parameter logic [LC3_W-1:0] KBDR_ADDR = LC3_KBDR_ADDR,
  parameter logic [LC3_W-1:0] DSR_ADDR  = LC3_DSR_ADDR,
  parameter logic [LC3_W-1:0] DDR_ADDR  = LC3_DDR_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_en,
  input  logic             io_wr,
  input  logic [LC3_W-1:0] io_addr,
  input  logic [7:0]       io_wdata,
  output logic [LC3_W-1:0] io_rdata,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_char,
  output logic             ddr_valid,
  output logic [7:0]       ddr_char,
  input  logic             ddr_ready
);

  logic       kbd_full;
  logic [7:0] kbd_data;
  logic       kbdr_rd;
  logic       ddr_wr;
  logic       kbd_take;

  // A KBDR read frees the buffer on the same edge, so a char arriving then is kept.
  always_comb begin
    kbdr_rd  = io_en && !io_wr && (io_addr == KBDR_ADDR);
    ddr_wr   = io_en && io_wr && (io_addr == DDR_ADDR);
    kbd_take = kbd_valid && (!kbd_full || kbdr_rd);
    io_rdata = '0;
    if (io_addr == KBSR_ADDR)
      io_rdata = {kbd_full, 15'b0};
    else if (io_addr == KBDR_ADDR)
      io_rdata = {8'h00, kbd_data};
    else if (io_addr == DSR_ADDR)
      io_rdata = {~ddr_valid, 15'b0};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kbd_full <= 1'b0;
      kbd_data <= '0;
    end else if (kbd_take) begin
      kbd_full <= 1'b1;
      kbd_data <= kbd_char;
    end else if (kbdr_rd) begin
      kbd_full <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ddr_valid <= 1'b0;
      ddr_char  <= '0;
    end else if (ddr_wr) begin
      ddr_valid <= 1'b1;
      ddr_char  <= io_wdata;
    end else if (ddr_valid && ddr_ready) begin
      ddr_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lc3_mem_if.sv
// LC-3 MAR/MDR and memory/IO responder: RAM ready/ack handshake, IO decode
// and the R completion pulse back to the control FSM.
module lc3_mem_if
  import lc3_pkg::*;
#(
  parameter logic [LC3_W-1:0] KBSR_ADDR = LC3_KBSR_ADDR,
  parameter logic [LC3_W-1:0] KBDR_ADDR = LC3_KBDR_ADDR,
  parameter logic [LC3_W-1:0] DSR_ADDR  = LC3_DSR_ADDR,
  parameter logic [LC3_W-1:0] DDR_ADDR  = LC3_DDR_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  inout  wire logic [LC3_W-1:0] main_bus,
  input  logic             GateMDR,
  input  logic             LDMAR,
  input  logic             LDMDR,
  input  logic             MIO_EN,
  input  logic             R_W,
  output logic             R,
  output logic             mem_req,
  output logic             mem_we,
  output logic [LC3_W-1:0] mem_addr,
  output logic [LC3_W-1:0] mem_wdata,
  input  logic [LC3_W-1:0] mem_rdata,
  input  logic             mem_ack,
  input  logic             kbd_valid,
  input  logic [7:0]       kbd_char,
  output logic             ddr_valid,
  output logic [7:0]       ddr_char,
  input  logic             ddr_ready
);

  mem_state_t       state;
  logic [LC3_W-1:0] mar;
  logic [LC3_W-1:0] mdr;
  logic [LC3_W-1:0] rdata_buf;
  logic             access_wr;
  logic             mar_is_io;
  logic             io_en;
  logic [LC3_W-1:0] io_rdata;

  assign main_bus  = GateMDR ? mdr : 'z;
  assign mar_is_io = (mar == KBSR_ADDR) || (mar == KBDR_ADDR) ||
                     (mar == DSR_ADDR)  || (mar == DDR_ADDR);
  assign io_en     = (state == IDLE) && MIO_EN && mar_is_io;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (LDMAR)
        mar <= main_bus;
      if (LDMDR)
        mdr <= MIO_EN ? rdata_buf : main_bus;
    end
  end

  // R is raised on the DONE->IDLE edge, so it is seen one cycle after DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      R         <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_buf <= '0;
      access_wr <= 1'b0;
    end else begin
      R <= 1'b0;
      case (state)
        IDLE: begin
          if (MIO_EN) begin
            access_wr <= R_W;
            if (R_W)
              mem_wdata <= mdr;
            if (mar_is_io) begin
              if (!R_W)
                rdata_buf <= io_rdata;
              state <= DONE;
            end else begin
              mem_req  <= 1'b1;
              mem_we   <= R_W;
              mem_addr <= mar;
              state    <= MEM;
            end
          end
        end
        MEM: begin
          if (mem_ack) begin
            if (!access_wr)
              rdata_buf <= mem_rdata;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            state   <= DONE;
          end
        end
        DONE: begin
          R     <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  lc3_io_regs #(
    .KBSR_ADDR(KBSR_ADDR),
    .KBDR_ADDR(KBDR_ADDR),
    .DSR_ADDR (DSR_ADDR),
    .DDR_ADDR (DDR_ADDR)
  ) u_io_regs (
    .clk      (clk),
    .rst      (rst),
    .io_en    (io_en),
    .io_wr    (R_W),
    .io_addr  (mar),
    .io_wdata (mdr[7:0]),
    .io_rdata (io_rdata),
    .kbd_valid(kbd_valid),
    .kbd_char (kbd_char),
    .ddr_valid(ddr_valid),
    .ddr_char (ddr_char),
    .ddr_ready(ddr_ready)
  );

endmodule

// File: tb/tb_lc3_mem_if.sv
// Bench for lc3_mem_if: hand-derived vector table, directed corner sequences
// and random accesses against a transaction-level model of RAM and IO state.
module tb_lc3_mem_if;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  wire  [15:0] main_bus;
  logic        tb_drv;
  logic [15:0] tb_bus;
  logic        GateMDR, LDMAR, LDMDR, MIO_EN, R_W;
  logic        R, mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;
  logic        kbd_valid, ddr_valid, ddr_ready;
  logic [7:0]  kbd_char, ddr_char;

  assign main_bus = tb_drv ? tb_bus : 16'hzzzz;

  lc3_mem_if dut (
    .clk(clk), .rst(rst), .main_bus(main_bus), .GateMDR(GateMDR),
    .LDMAR(LDMAR), .LDMDR(LDMDR), .MIO_EN(MIO_EN), .R_W(R_W), .R(R),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .kbd_valid(kbd_valid), .kbd_char(kbd_char), .ddr_valid(ddr_valid),
    .ddr_char(ddr_char), .ddr_ready(ddr_ready)
  );

  int checks = 0;
  int errors = 0;

  // RAM seen by the DUT, and the model's own view of what RAM should hold.
  logic [15:0] ram     [0:65535];
  logic [15:0] exp_mem [0:65535];

  logic       m_kfull;
  logic [7:0] m_kdata;
  logic       m_dvalid;
  logic [7:0] m_dchar;

  typedef struct {
    logic [15:0] addr;
    logic        wr;
    logic [15:0] wdata;
    int          dly;
    logic [15:0] exp_rd;
    logic        exp_dv;
  } vec_t;

  vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_kfull  = 1'b0;
    m_kdata  = 8'h00;
    m_dvalid = 1'b0;
    m_dchar  = 8'h00;
  endtask

  // Transaction-level effect of one access; side inputs act on its first edge.
  task automatic model_access(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                              input logic kv, input logic [7:0] kc, input logic dr,
                              output logic [15:0] exp_rd, output logic io);
    logic kbd_rd;
    io     = addr inside {16'hFE00, 16'hFE02, 16'hFE04, 16'hFE06};
    exp_rd = 16'h0000;
    kbd_rd = io && !wr && (addr == 16'hFE02);
    if (!io) begin
      if (wr) exp_mem[addr] = wdata;
      exp_rd = exp_mem[addr];
    end else if (!wr) begin
      if (addr == 16'hFE00)      exp_rd = m_kfull ? 16'h8000 : 16'h0000;
      else if (addr == 16'hFE02) exp_rd = {8'h00, m_kdata};
      else if (addr == 16'hFE04) exp_rd = m_dvalid ? 16'h0000 : 16'h8000;
    end
    if (kbd_rd) m_kfull = 1'b0;
    if (kv && !m_kfull) begin
      m_kdata = kc;
      m_kfull = 1'b1;
    end
    if (dr) m_dvalid = 1'b0;
    if (io && wr && addr == 16'hFE06) begin
      m_dvalid = 1'b1;
      m_dchar  = wdata[7:0];
    end
  endtask

  // Drives one access like the LC-3 control FSM and plays the RAM side.
  task automatic do_access(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                           input int ack_dly, input logic kv, input logic [7:0] kc,
                           input logic dr, input logic poke,
                           output logic [15:0] rdata, output int lat, output int req_cyc);
    logic hold_ok;
    logic got_r;
    hold_ok = 1'b1;
    got_r   = 1'b0;
    lat     = 0;
    req_cyc = 0;
    @(negedge clk);
    tb_drv = 1'b1; tb_bus = addr; LDMAR = 1'b1;
    @(negedge clk);
    LDMAR = 1'b0;
    if (wr) begin
      tb_bus = wdata; LDMDR = 1'b1; MIO_EN = 1'b0;
      @(negedge clk);
      LDMDR = 1'b0;
    end
    tb_drv = 1'b0;
    MIO_EN = 1'b1; R_W = wr; LDMDR = !wr;
    kbd_valid = kv; kbd_char = kc; ddr_ready = dr;
    for (int i = 0; i < 100 && !got_r; i++) begin
      @(posedge clk); #1;
      lat++;
      kbd_valid = 1'b0; ddr_ready = 1'b0; mem_ack = 1'b0; LDMAR = 1'b0; tb_drv = 1'b0;
      if (R) begin
        got_r = 1'b1;
      end else if (mem_req) begin
        req_cyc++;
        if (mem_addr !== addr || mem_we !== wr || (wr && mem_wdata !== wdata))
          hold_ok = 1'b0;
        if (poke && req_cyc == 1) begin
          tb_drv = 1'b1; tb_bus = 16'h5555; LDMAR = 1'b1;
        end
        if (req_cyc == ack_dly) begin
          mem_ack   = 1'b1;
          mem_rdata = ram[mem_addr];
          if (wr) ram[mem_addr] = mem_wdata;
        end
      end
    end
    MIO_EN = 1'b0; LDMDR = 1'b0; R_W = 1'b0; mem_ack = 1'b0;
    chk($sformatf("r_seen[%h]", addr), {31'd0, got_r}, 32'd1);
    chk($sformatf("mem_hold[%h]", addr), {31'd0, hold_ok}, 32'd1);
    GateMDR = 1'b1;
    #1 rdata = main_bus;
    GateMDR = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("r_single[%h]", addr), {31'd0, R}, 32'd0);
  endtask

  task automatic run(input logic [15:0] addr, input logic wr, input logic [15:0] wdata,
                     input int dly, input logic kv, input logic [7:0] kc, input logic dr,
                     input logic poke, output logic [15:0] rd);
    logic [15:0] exp_rd;
    logic        io;
    int          lat, req;
    model_access(addr, wr, wdata, kv, kc, dr, exp_rd, io);
    do_access(addr, wr, wdata, dly, kv, kc, dr, poke, rd, lat, req);
    if (!wr) chk($sformatf("rdata[%h]", addr), {16'd0, rd}, {16'd0, exp_rd});
    chk($sformatf("latency[%h]", addr), lat, io ? 2 : dly + 2);
    chk($sformatf("req_cycles[%h]", addr), req, io ? 0 : dly);
    chk("ddr_valid", {31'd0, ddr_valid}, {31'd0, m_dvalid});
    chk("ddr_char", {24'd0, ddr_char}, {24'd0, m_dchar});
  endtask

  task automatic pulse_kbd(input logic [7:0] c);
    @(negedge clk);
    kbd_valid = 1'b1; kbd_char = c;
    @(negedge clk);
    kbd_valid = 1'b0;
    if (!m_kfull) begin
      m_kdata = c;
      m_kfull = 1'b1;
    end
  endtask

  task automatic pulse_ready();
    @(negedge clk);
    ddr_ready = 1'b1;
    @(negedge clk);
    ddr_ready = 1'b0;
    m_dvalid = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rd;
    logic [15:0] a;
    int          sel;

    for (int i = 0; i < 65536; i++) begin
      ram[i]     = i[15:0] ^ 16'hA5A5;
      exp_mem[i] = i[15:0] ^ 16'hA5A5;
    end
    ram[16'h3000]     = 16'hBEEF;
    exp_mem[16'h3000] = 16'hBEEF;
    model_reset();

    tb_drv = 1'b0; tb_bus = '0; GateMDR = 1'b0; LDMAR = 1'b0; LDMDR = 1'b0;
    MIO_EN = 1'b0; R_W = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    kbd_valid = 1'b0; kbd_char = '0; ddr_ready = 1'b0;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b1;

    chk("rst_R", {31'd0, R}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    chk("rst_ddr_valid", {31'd0, ddr_valid}, 32'd0);
    chk("rst_ddr_char", {24'd0, ddr_char}, 32'd0);
    GateMDR = 1'b1;
    #1 chk("rst_mdr_on_bus", {16'd0, main_bus}, 32'd0);
    GateMDR = 1'b0;

    tbl[0]  = '{16'hFE00, 1'b0, 16'h0000, 1, 16'h0000, 1'b0};
    tbl[1]  = '{16'hFE04, 1'b0, 16'h0000, 1, 16'h8000, 1'b0};
    tbl[2]  = '{16'hFE06, 1'b1, 16'h0058, 1, 16'h0000, 1'b1};
    tbl[3]  = '{16'hFE04, 1'b0, 16'h0000, 1, 16'h0000, 1'b1};
    tbl[4]  = '{16'hFE06, 1'b0, 16'h0000, 1, 16'h0000, 1'b1};
    tbl[5]  = '{16'hFE08, 1'b0, 16'h0000, 1, 16'h5BAD, 1'b1};
    tbl[6]  = '{16'hFE01, 1'b0, 16'h0000, 2, 16'h5BA4, 1'b1};
    tbl[7]  = '{16'hFFFE, 1'b1, 16'h1234, 3, 16'h0000, 1'b1};
    tbl[8]  = '{16'hFFFE, 1'b0, 16'h0000, 1, 16'h1234, 1'b1};
    tbl[9]  = '{16'hFE02, 1'b0, 16'h0000, 1, 16'h0000, 1'b1};
    tbl[10] = '{16'h3000, 1'b0, 16'h0000, 3, 16'hBEEF, 1'b1};
    tbl[11] = '{16'hFDFE, 1'b0, 16'h0000, 4, 16'h585B, 1'b1};

    for (int i = 0; i < 12; i++) begin
      run(tbl[i].addr, tbl[i].wr, tbl[i].wdata, tbl[i].dly, 1'b0, 8'h00, 1'b0, 1'b0, rd);
      if (!tbl[i].wr) chk($sformatf("tbl_rdata[%0d]", i), {16'd0, rd}, {16'd0, tbl[i].exp_rd});
      chk($sformatf("tbl_ddr_valid[%0d]", i), {31'd0, ddr_valid}, {31'd0, tbl[i].exp_dv});
    end
    chk("tbl_ddr_char", {24'd0, ddr_char}, 32'h58);

    // RAM write with MAR reloaded mid-access.
    run(16'h4000, 1'b1, 16'h1234, 2, 1'b0, 8'h00, 1'b0, 1'b1, rd);
    chk("ram_write_landed", {16'd0, ram[16'h4000]}, 32'h1234);

    // Keyboard.
    pulse_kbd(8'h41);
    run(16'hFE00, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("kbsr_full", {16'd0, rd}, 32'h8000);
    run(16'hFE02, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("kbdr_41", {16'd0, rd}, 32'h0041);
    run(16'hFE00, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("kbsr_empty", {16'd0, rd}, 32'h0000);
    pulse_kbd(8'h41);
    pulse_kbd(8'h42);
    run(16'hFE02, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("kbd_drop_while_full", {16'd0, rd}, 32'h0041);
    pulse_kbd(8'h43);
    run(16'hFE02, 1'b0, 16'h0, 1, 1'b1, 8'h44, 1'b0, 1'b0, rd);
    chk("kbdr_same_cycle_old", {16'd0, rd}, 32'h0043);
    run(16'hFE00, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("kbsr_same_cycle_full", {16'd0, rd}, 32'h8000);
    run(16'hFE02, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("kbdr_same_cycle_new", {16'd0, rd}, 32'h0044);

    // Display.
    pulse_ready();
    chk("ddr_consumed", {31'd0, ddr_valid}, 32'd0);
    run(16'hFE04, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("dsr_ready", {16'd0, rd}, 32'h8000);
    run(16'hFE06, 1'b1, 16'h0059, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    run(16'hFE04, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("dsr_busy", {16'd0, rd}, 32'h0000);
    run(16'hFE06, 1'b1, 16'h005A, 1, 1'b0, 8'h00, 1'b1, 1'b0, rd);
    chk("ddr_same_cycle_valid", {31'd0, ddr_valid}, 32'd1);
    chk("ddr_same_cycle_char", {24'd0, ddr_char}, 32'h5A);

    // Random accesses against the model.
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 7);
      case (sel)
        0: a = 16'hFE00;
        1: a = 16'hFE02;
        2: a = 16'hFE04;
        3: a = 16'hFE06;
        4: a = 16'hFE08;
        5: a = 16'hFFFF;
        default: a = $urandom_range(0, 65535);
      endcase
      run(a, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 65535)), $urandom_range(1, 4),
          ($urandom_range(0, 2) == 0), 8'($urandom_range(0, 255)), ($urandom_range(0, 2) == 0),
          1'b0, rd);
    end

    // Reset in the middle of a RAM access.
    run(16'hFE06, 1'b1, 16'h0077, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    pulse_kbd(8'h55);
    @(negedge clk);
    tb_drv = 1'b1; tb_bus = 16'h3000; LDMAR = 1'b1;
    @(negedge clk);
    LDMAR = 1'b0; tb_drv = 1'b0; MIO_EN = 1'b1; R_W = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk("pre_reset_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk) rst = 1'b0;
    #1;
    chk("async_rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("async_rst_R", {31'd0, R}, 32'd0);
    chk("async_rst_ddr_valid", {31'd0, ddr_valid}, 32'd0);
    MIO_EN = 1'b0;
    @(negedge clk) rst = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1 chk("post_rst_idle", {31'd0, mem_req}, 32'd0);
    run(16'hFE00, 1'b0, 16'h0, 1, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("post_rst_kbsr", {16'd0, rd}, 32'h0000);
    run(16'h3000, 1'b0, 16'h0, 2, 1'b0, 8'h00, 1'b0, 1'b0, rd);
    chk("post_rst_ram_read", {16'd0, rd}, 32'hBEEF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
